// File: rtl/store_merge_ctrl.sv
// Store-path controller: word stores go straight to memory, sub-word stores
// read-modify-write the aligned word, and misaligned/invalid requests raise a one-cycle exception.
module store_merge_ctrl #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] B_out,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign_exc
);

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        EXC
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic [1:0]       type_q;
    logic [31:0]      b_q;
    logic             req_bad;

    // Replace the addressed byte or halfword of the read word with store data.
    function automatic logic [31:0] merge_word(input logic [31:0] rdata,
                                               input logic [31:0] b,
                                               input logic [1:0]  typ,
                                               input logic [1:0]  a);
        logic [31:0] w;
        w = rdata;
        if (typ == ST_SB) begin
            w[{a, 3'b000} +: 8] = b[7:0];
        end else begin
            w[{a[1], 4'b0000} +: 16] = b[15:0];
        end
        return w;
    endfunction

    always_comb begin
        req_bad = 1'b0;
        case (store_type)
            ST_SW:   req_bad = (addr[1:0] != 2'b00);
            ST_SH:   req_bad = addr[0];
            ST_SB:   req_bad = 1'b0;
            default: req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            type_q       <= '0;
            b_q          <= '0;
            mem_addr     <= '0;
            mem_wr       <= 1'b0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            misalign_exc <= 1'b0;
        end else begin
            mem_wr       <= 1'b0;
            done         <= 1'b0;
            misalign_exc <= 1'b0;
            case (state)
                IDLE: begin
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    busy      <= 1'b0;
                    if (start) begin
                        addr_q <= addr;
                        type_q <= store_type;
                        b_q    <= B_out;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        if (req_bad) begin
                            state        <= EXC;
                            misalign_exc <= 1'b1;
                        end else if (store_type == ST_SW) begin
                            state     <= WRITE;
                            mem_wr    <= 1'b1;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= B_out;
                        end else begin
                            state    <= READ;
                            mem_addr <= {addr[31:2], 2'b00};
                        end
                    end
                end
                // Hold the read address READ_LAT+1 cycles, then capture the merged word.
                READ: begin
                    if (cnt == CNT_LAST) begin
                        state     <= WRITE;
                        mem_wr    <= 1'b1;
                        mem_wdata <= merge_word(mem_rdata, b_q, type_q, addr_q[1:0]);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    state     <= DONE;
                    done      <= 1'b1;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                EXC: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_ctrl.sv
// Directed bench: two controllers (read latency 1 and 3) share stimulus and are
// checked cycle by cycle against hand-derived timing and merged-data values.
module tb_store_merge_ctrl;

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;
    localparam logic [1:0] ST_XX = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  store_type = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] b_out = '0;

    logic [31:0] ma1, wd1, rd1, ma3, wd3, rd3;
    logic        wr1, bs1, dn1, ex1, wr3, bs3, dn3, ex3;
    logic [31:0] p1, p3a, p3b, p3c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_merge_ctrl #(.READ_LAT(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .store_type(store_type),
        .addr(addr), .B_out(b_out), .mem_rdata(rd1), .mem_addr(ma1),
        .mem_wr(wr1), .mem_wdata(wd1), .busy(bs1), .done(dn1), .misalign_exc(ex1)
    );

    store_merge_ctrl #(.READ_LAT(3)) u3 (
        .clk(clk), .reset(reset), .start(start), .store_type(store_type),
        .addr(addr), .B_out(b_out), .mem_rdata(rd3), .mem_addr(ma3),
        .mem_wr(wr3), .mem_wdata(wd3), .busy(bs3), .done(dn3), .misalign_exc(ex3)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: mem_word = 32'hDEADBEEF;
            32'h104: mem_word = 32'h11223344;
            default: mem_word = 32'hA5A5A5A5;
        endcase
    endfunction

    // Memory read pipelines matching each instance's latency.
    always @(posedge clk) begin
        p1  <= mem_word(ma1);
        p3a <= mem_word(ma3);
        p3b <= p3a;
        p3c <= p3b;
    end
    assign rd1 = p1;
    assign rd3 = p3c;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Expected outputs for one instance at cycle c of a request.
    task automatic chk_dut(input string who, input int lat, input int c, input logic [1:0] typ,
                           input logic exc, input logic [31:0] aligned, input logic [31:0] data,
                           input logic wr, input logic dn, input logic ex, input logic bs,
                           input logic [31:0] ma, input logic [31:0] md);
        int wrc, dnc;
        logic e_wr, e_dn, e_ex, e_bs;
        logic [31:0] e_ma, e_md;
        wrc = (typ == ST_SW) ? 1 : 2 + lat;
        dnc = wrc + 1;
        if (exc) begin
            e_bs = (c == 1); e_ex = (c == 1); e_wr = 1'b0; e_dn = 1'b0;
            e_ma = '0; e_md = '0;
        end else begin
            e_bs = (c >= 1) && (c <= dnc);
            e_ex = 1'b0;
            e_wr = (c == wrc);
            e_dn = (c == dnc);
            e_ma = (c >= 1 && c <= wrc) ? aligned : 32'h0;
            e_md = (c == wrc) ? data : 32'h0;
        end
        chk($sformatf("%s c%0d mem_wr", who, c), 32'(wr), 32'(e_wr));
        chk($sformatf("%s c%0d done", who, c), 32'(dn), 32'(e_dn));
        chk($sformatf("%s c%0d exc", who, c), 32'(ex), 32'(e_ex));
        chk($sformatf("%s c%0d busy", who, c), 32'(bs), 32'(e_bs));
        chk($sformatf("%s c%0d mem_addr", who, c), ma, e_ma);
        chk($sformatf("%s c%0d mem_wdata", who, c), md, e_md);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " L1 outs"}, {ma1 | wd1}, 32'h0);
        chk({tag, " L1 flags"}, 32'({wr1, bs1, dn1, ex1}), 32'h0);
        chk({tag, " L3 outs"}, {ma3 | wd3}, 32'h0);
        chk({tag, " L3 flags"}, 32'({wr3, bs3, dn3, ex3}), 32'h0);
    endtask

    task automatic run_req(input string name, input logic [1:0] typ, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] data, input logic exc,
                           input logic repulse);
        logic [31:0] aligned;
        aligned = {a[31:2], 2'b00};
        store_type = typ; addr = a; b_out = b; start = 1'b1;
        step();
        for (int c = 1; c <= 8; c++) begin
            chk_dut({name, " L1"}, 1, c, typ, exc, aligned, data, wr1, dn1, ex1, bs1, ma1, wd1);
            chk_dut({name, " L3"}, 3, c, typ, exc, aligned, data, wr3, dn3, ex3, bs3, ma3, wd3);
            if (repulse && c <= 3) begin
                start = 1'b1; addr = 32'h10C; b_out = 32'hFFFFFFFF;
            end else begin
                start = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        step();
        step();
        chk_zero("reset");
        reset = 1'b0;
        step();
        chk_zero("idle");

        run_req("sw108",  ST_SW, 32'h108, 32'h01020304, 32'h01020304, 1'b0, 1'b0);
        run_req("sb102",  ST_SB, 32'h102, 32'h123456AB, 32'hDEABBEEF, 1'b0, 1'b0);
        run_req("sh106",  ST_SH, 32'h106, 32'hCAFEF00D, 32'hF00D3344, 1'b0, 1'b0);
        run_req("sh104",  ST_SH, 32'h104, 32'h0000BEEF, 32'h1122BEEF, 1'b0, 1'b0);
        run_req("sb101",  ST_SB, 32'h101, 32'h000000AB, 32'hDEADABEF, 1'b0, 1'b0);
        run_req("sb107",  ST_SB, 32'h107, 32'h0000005A, 32'h5A223344, 1'b0, 1'b0);
        run_req("sb104",  ST_SB, 32'h104, 32'hFFFFFF77, 32'h11223377, 1'b0, 1'b0);
        run_req("sh105",  ST_SH, 32'h105, 32'h12345678, 32'h0, 1'b1, 1'b0);
        run_req("sw10a",  ST_SW, 32'h10A, 32'h12345678, 32'h0, 1'b1, 1'b0);
        run_req("inv100", ST_XX, 32'h100, 32'h12345678, 32'h0, 1'b1, 1'b0);

        // Reset during the READ phase drops the pending write.
        store_type = ST_SB; addr = 32'h102; b_out = 32'h123456AB; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_zero("rst c3");
        for (int c = 4; c <= 9; c++) begin
            chk($sformatf("rst c%0d no wr/done", c), 32'({wr1, dn1, wr3, dn3}), 32'h0);
            step();
        end
        run_req("sw_after_rst", ST_SW, 32'h200, 32'hA1B2C3D4, 32'hA1B2C3D4, 1'b0, 1'b0);

        run_req("sb_repulse", ST_SB, 32'h102, 32'h123456AB, 32'hDEABBEEF, 1'b0, 1'b1);
        chk_zero("final idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_merge_ctrl.md
# store_merge_ctrl

Store-path controller for the multicycle CPU: the memory-write side that complements the write-back selector feeding the register file. It takes a store request (SW/SH/SB) with the B register value and the byte address from ALUOut. For sub-word stores it performs a read-modify-write of the aligned memory word; for word stores it writes directly. It raises a one-cycle exception pulse on misaligned or invalid requests. It sits between the control unit, the B register and the memory address/data/write-enable inputs.

## Interface
- READ_LAT, 1, memory read latency in cycles (address presented in cycle n → mem_rdata valid in cycle n+READ_LAT); legal range 1..7
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- store_type  input  2  00 SW, 01 SH, 10 SB, 11 invalid
- addr  input  32  byte address (ALUOut)
- B_out  input  32  store data from register B
- mem_rdata  input  32  memory read data
- mem_addr  output  32  word-aligned memory address
- mem_wr  output  1  memory write enable
- mem_wdata  output  32  memory write data
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle completion pulse
- misalign_exc  output  1  one-cycle exception pulse; no memory write occurs

## Operation
- Byte lanes are little-endian: lane k is bits 8k+7:8k, selected by addr[1:0]; halfword lane is bits 15:0 when addr[1]=0, bits 31:16 when addr[1]=1.
- IDLE + start: latch addr, store_type and B_out into internal registers; later changes on those inputs are ignored.
- Validity: SW requires addr[1:0]=00; SH requires addr[0]=0; SB is always aligned; store_type 11 is invalid.
- Transitions:
  - Invalid or misaligned request → EXC.
  - SW → WRITE.
  - SH/SB → READ.
- READ: mem_addr={addr_q[31:2],2'b00}, mem_wr=0. A 3-bit counter holds the state for READ_LAT+1 cycles. At the closing edge of the last READ cycle, the block registers the merged word:
  - SB: mem_rdata with the selected lane replaced by B_q[7:0].
  - SH: mem_rdata with the selected half replaced by B_q[15:0].
  - Then → WRITE.
- WRITE: mem_wr=1, mem_addr as above, mem_wdata = B_q (SW) or the merged word (SH/SB); lasts one cycle → DONE.
- DONE: done=1 for one cycle → IDLE.
- EXC: misalign_exc=1 for one cycle, mem_wr stays 0, done stays 0 → IDLE.
- start while busy is ignored; it is not queued.
- All outputs are registered, with no combinational input→output path.

## Timing
- Reset: state=IDLE, counter=0; mem_addr=0, mem_wr=0, mem_wdata=0, busy=0, done=0, misalign_exc=0. In IDLE, mem_addr and mem_wdata are driven to 0.
- Cycle 0 denotes the cycle in which start is high in IDLE.
- SW: busy 1..2; mem_wr high in cycle 1; done high in cycle 2; IDLE in cycle 3, where a new start is accepted.
- SH/SB: READ occupies cycles 1..1+READ_LAT; mem_wr high in cycle 2+READ_LAT; done high in cycle 3+READ_LAT. With READ_LAT=1: write in cycle 3, done in cycle 4.
- EXC: misalign_exc and busy high in cycle 1 only.
- Reset in any state: at that edge, all outputs and state return to reset values. A pending write is dropped and no done is produced. If reset and start coincide, reset wins.
- mem_wr is never high for more than one consecutive cycle per request.

## Test plan
- SW, addr=0x108, B_out=0x01020304 → cycle 1: mem_wr=1, mem_addr=0x108, mem_wdata=0x01020304; cycle 2: done=1; no READ cycle.
- SB, READ_LAT=1, addr=0x102, B_out=0x123456AB, memory[0x100]=0xDEADBEEF → READ cycles 1-2 at mem_addr=0x100; cycle 3: mem_wr=1, mem_wdata=0xDEABBEEF; cycle 4: done=1.
- SH, READ_LAT=3, addr=0x106, B_out=0xCAFEF00D, memory[0x104]=0x11223344 → mem_wr only in cycle 5 with mem_wdata=0xF00D3344; done in cycle 6.
- SH at addr=0x105 and SW at 0x10A (separate runs), plus store_type=11 → misalign_exc=1 in cycle 1; mem_wr=0 and done=0 throughout; IDLE in cycle 2.
- Reset asserted in cycle 2 of an SB with READ_LAT=1 → from cycle 3, all outputs are 0; no mem_wr and no done; a following SW is served normally.
- start re-pulsed in cycles 1-3 with a different addr during an SB → ignored; the write uses the original address; exactly one done.
